// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_pkg
//   Shared definitions for the instruction-memory boot loader. The CPU
//   testbench imports this package to get the same state encodings and image
//   framing constants.
//   Contents:
//     state_e         loader FSM state encoding (ST_LEN .. ST_ERR)
//     BYTES_PER_WORD  image bytes per instruction word
//     LEN_W           width of the image length field in bits
//     is_loading()    true in the states that accept image bytes
// ---------------------------------------------------------------------------
package imem_boot_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 32;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,  // collecting the 4-byte big-endian word count
        ST_DATA = 3'd1,  // collecting instruction words
        ST_CSUM = 3'd2,  // waiting for the trailing checksum byte
        ST_RUN  = 3'd3,  // image good, CPU released (terminal)
        ST_ERR  = 3'd4   // image rejected (terminal)
    } state_e;

    // The loader accepts bytes, and reports busy, only while an image is
    // still being received.
    function automatic logic is_loading(input state_e st);
        return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage : imem_boot_loader_pkg

// File: rtl/imem_boot_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//   Packs a byte stream MSB-first into 32-bit words. A 2-bit index counts the
//   bytes of the current word. The word is presented combinationally in the
//   same cycle its 4th byte arrives, so the parent can register it with a
//   fixed single-cycle latency. The parent uses it for both the length field
//   and the data words.
//   Ports:
//     clk_i             system clock, rising edge
//     rst_n_i           asynchronous active-low reset
//     clear_i           drop any partial word and restart at byte 0
//     in_valid_i        in_byte_i is accepted this cycle
//     in_byte_i  [7:0]  incoming byte
//     out_word_valid_o  this cycle completes a word
//     out_word_o [31:0] completed word (valid with out_word_valid_o)
// ---------------------------------------------------------------------------
module byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clear_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_byte_i,
    output logic        out_word_valid_o,
    output logic [31:0] out_word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] shift_q, shift_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear_i) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (in_valid_i) begin
            shift_d = {shift_q[23:0], in_byte_i};
            // Wraps 3 -> 0 naturally, which starts the next word.
            idx_d   = idx_q + 2'd1;
        end
    end

    assign out_word_valid_o = in_valid_i && !clear_i
                              && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign out_word_o       = {shift_q[23:0], in_byte_i};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of block order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule : byte_packer

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Boot stage for the single-cycle CPU. It receives a program image as a
//   byte stream, writes it into instruction memory one 32-bit word at a time,
//   verifies the image checksum and then raises run_o to release the CPU.
//   Image format (big-endian): 4-byte word count N, N*4 instruction bytes,
//   1 checksum byte. The 8-bit sum of all image bytes must be 0x00.
//   Ports:
//     clk_i                    system clock, rising edge
//     rst_n_i                  asynchronous active-low reset
//     byte_in_i    [7:0]       incoming image byte
//     byte_valid_i             byte_in_i is valid this cycle
//     byte_ready_o             loader accepts a byte (transfer = valid & ready)
//     imem_wr_o                one-cycle instruction-memory write strobe
//     imem_addr_o  [ADDR_W-1:0] word address of the write
//     imem_data_o  [31:0]      instruction word of the write
//     run_o                    CPU run enable, held after a good load
//     busy_o                   load in progress (LEN, DATA, CSUM)
//     error_o                  load failed (length overflow or bad checksum)
//     word_count_o [ADDR_W:0]  words written so far in this load
// ---------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_wr_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              run_o,
    output logic              busy_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o
);

    // The length field is compared at its full width, so a huge N cannot
    // alias onto a small one.
    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1) << ADDR_W;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    n_q, n_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;

    logic                accept;
    logic                pack_valid;
    logic                pack_word_valid;
    logic [31:0]         pack_word;
    logic [ADDR_W:0]     word_cnt_inc;

    assign byte_ready_o = is_loading(state_q);
    assign accept       = byte_valid_i && byte_ready_o;

    // The packer only sees length and data bytes; the checksum byte is
    // consumed directly by the FSM. It is held cleared once the load ends.
    assign pack_valid = accept && ((state_q == ST_LEN) || (state_q == ST_DATA));

    byte_packer u_packer (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .clear_i          (!byte_ready_o),
        .in_valid_i       (pack_valid),
        .in_byte_i        (byte_in_i),
        .out_word_valid_o (pack_word_valid),
        .out_word_o       (pack_word)
    );

    // N never exceeds MAX_WORDS, so this increment cannot wrap.
    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        sum_d      = sum_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        // Running checksum covers every accepted byte, including the
        // checksum byte itself; it wraps at 8 bits.
        if (accept) begin
            sum_d = sum_q + byte_in_i;
        end

        unique case (state_q)
            ST_LEN: begin
                if (pack_word_valid) begin
                    n_d = pack_word;
                    if (pack_word > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (pack_word == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // The completed word is registered here, giving a write
                // strobe exactly one cycle after its last byte. A new word
                // needs 4 more bytes, so strobes are never adjacent.
                if (pack_word_valid) begin
                    wr_d       = 1'b1;
                    addr_d     = word_cnt_q[ADDR_W-1:0];
                    data_d     = pack_word;
                    word_cnt_d = word_cnt_inc;
                    if (LEN_W'(word_cnt_inc) == n_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (sum_d == 8'h00) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN, ST_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // NOTE: all loader registers, including the write-data holding register,
    // are reset so a mid-load reset leaves nothing stale on the outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_LEN;
            n_q        <= '0;
            word_cnt_q <= '0;
            sum_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            sum_q      <= sum_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign imem_wr_o    = wr_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign run_o        = (state_q == ST_RUN);
    assign error_o      = (state_q == ST_ERR);
    assign busy_o       = is_loading(state_q);
    assign word_count_o = word_cnt_q;

endmodule : imem_boot_loader

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Self-checking bench for imem_boot_loader. Stimulus pushes the expected
//   instruction-memory writes into a queue; a monitor pops and compares each
//   write strobe as it appears, and also checks strobe width and that run and
//   error are never high together. Directed checks cover reset state, final
//   status and boundary cases.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_wr;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              run;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int n_vec  = 0;
    int n_fail = 0;

    wr_t exp_q[$];
    logic prev_wr = 1'b0;

    // Test 1 image: N=2, 0x20010005, 0x00000000. Byte sum before the
    // checksum is 0x02+0x20+0x01+0x05 = 0x28, so the checksum is 0xD8.
    logic [7:0] img1 [13] = '{8'h00, 8'h00, 8'h00, 8'h02,
                              8'h20, 8'h01, 8'h00, 8'h05,
                              8'h00, 8'h00, 8'h00, 8'h00,
                              8'hD8};

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .byte_in_i    (byte_in),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .imem_wr_o    (imem_wr),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .run_o        (run),
        .busy_o       (busy),
        .error_o      (error),
        .word_count_o (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write strobe against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("run_and_error_exclusive", 32'(run & error), 32'd0);
            if (imem_wr) begin
                check("wr_pulse_width", 32'(prev_wr), 32'd0);
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e.addr));
                    check("wr_data", imem_data, e.data);
                end
            end
        end
        prev_wr = imem_wr;
    end

    // Watchdog: the bench never waits on the DUT unboundedly, but guard anyway.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Present one byte for one cycle after 'gap' idle cycles; returns on the
    // falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_img1_writes();
        exp_q.push_back('{addr: 10'd0, data: 32'h2001_0005});
        exp_q.push_back('{addr: 10'd1, data: 32'h0000_0000});
    endtask

    task automatic send_img1(input int max_gap);
        push_img1_writes();
        for (int i = 0; i < 12; i++) begin
            send_byte(img1[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
        check("busy_before_csum", 32'(busy), 32'd1);
        check("run_before_csum", 32'(run), 32'd0);
        send_byte(img1[12], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        check("run_cycle_after_csum", 32'(run), 32'd1);
    endtask

    task automatic check_end(input string tag, input logic exp_run,
                             input logic exp_err, input int exp_wc);
        repeat (2) @(negedge clk);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_run"}, 32'(run), 32'(exp_run));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
        exp_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        #12;
        // Reset state
        check("rst_ready", 32'(byte_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_run", 32'(run), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wr", 32'(imem_wr), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: good image at one byte per cycle; extra byte after RUN ignored.
        send_img1(0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        check_end("t1", 1'b1, 1'b0, 2);

        // Test 2: checksum corrupted.
        do_reset();
        push_img1_writes();
        for (int i = 0; i < 12; i++) send_byte(img1[i], 0);
        send_byte(img1[12] ^ 8'h01, 0);
        check("t2_error_cycle_after_csum", 32'(error), 32'd1);
        check_end("t2", 1'b0, 1'b1, 2);

        // Test 3: N = MAX_WORDS + 1 is rejected right after the length field.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        check("t3_error_before_len_done", 32'(error), 32'd0);
        send_byte(8'h01, 0);
        check("t3_error_after_len", 32'(error), 32'd1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        check_end("t3", 1'b0, 1'b1, 0);

        // Test 3b: N = MAX_WORDS exactly is accepted into DATA.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        check("t3b_max_words_no_error", 32'(error), 32'd0);
        check("t3b_max_words_ready", 32'(byte_ready), 32'd1);

        // Test 4: empty image, good then bad checksum.
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'h00, 0);
        check_end("t4a", 1'b1, 1'b0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        check_end("t4b", 1'b0, 1'b1, 0);

        // Test 5: same image as test 1 with random gaps of 0-5 cycles.
        do_reset();
        send_img1(5);
        check_end("t5", 1'b1, 1'b0, 2);

        // Test 6: reset after 6 data bytes, then a full reload.
        do_reset();
        exp_q.push_back('{addr: 10'd0, data: 32'h2001_0005});
        for (int i = 0; i < 10; i++) send_byte(img1[i], 0);
        check("t6_partial_word_count", 32'(word_count), 32'd1);
        check("t6_partial_writes_done", 32'(exp_q.size()), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_word_count", 32'(word_count), 32'd0);
        check("t6_async_ready", 32'(byte_ready), 32'd1);
        check("t6_async_wr", 32'(imem_wr), 32'd0);
        check("t6_async_run", 32'(run), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_img1(0);
        check_end("t6", 1'b1, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_imem_boot_loader
